// File: rtl/single_cycle_processor.sv
// Single-cycle RV32I core with private instruction memory, register file and data memory.
// Fetch, decode, execute, memory access and writeback all complete within one clock.

module scp_inst_mem #(
  parameter int unsigned Depth = 1024,
  localparam int unsigned Aw = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem [0:Depth-1];

  // Load port; the core itself never writes instruction memory.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];
endmodule

module scp_reg_file (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] reg_mem [0:31];

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i != 5'd0)) reg_mem[waddr_i] <= wdata_i;
  end

  // x0 is hardwired to zero regardless of what its storage holds.
  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : reg_mem[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : reg_mem[raddr2_i];
endmodule

module scp_data_mem #(
  parameter int unsigned Depth = 1024,
  localparam int unsigned Aw = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem [0:Depth-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];
endmodule

module single_cycle_processor #(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  // Depths are powers of two, so the modulo indexing is a plain bit slice.
  localparam int unsigned IAw = $clog2(IMEM_DEPTH);
  localparam int unsigned DAw = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;
  localparam logic [6:0] OpJal    = 7'h6f;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpReg    = 7'h33;

  logic [31:0] pc_out, pc_next, pc_plus4, inst;
  logic        br_taken, jump;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] alu_b, alu_res;
  logic [2:0]  alu_f3;
  logic        alu_alt;
  logic        br_cond;
  logic        rf_we, dm_we;
  logic [31:0] rf_wdata, dm_rdata, dm_wdata;
  logic [3:0]  dm_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  scp_inst_mem #(.Depth(IMEM_DEPTH)) inst_mem_i (
    .clk_i   (clk),
    .we_i    (1'b0),
    .waddr_i ({IAw{1'b0}}),
    .wdata_i (32'd0),
    .raddr_i (pc_out[IAw+1:2]),
    .rdata_o (inst)
  );

  scp_reg_file reg_file_i (
    .clk_i    (clk),
    .we_i     (rf_we & ~rst),
    .waddr_i  (rd),
    .wdata_i  (rf_wdata),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_val),
    .rdata2_o (rs2_val)
  );

  scp_data_mem #(.Depth(DMEM_DEPTH)) data_mem_i (
    .clk_i   (clk),
    .we_i    (dm_we & ~rst),
    .be_i    (dm_be),
    .addr_i  (alu_res[DAw+1:2]),
    .wdata_i (dm_wdata),
    .rdata_o (dm_rdata)
  );

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign pc_plus4 = pc_out + 32'd4;

  // Loads and stores reuse the ALU adder for the effective address.
  always_comb begin
    alu_b   = imm_i;
    alu_f3  = funct3;
    alu_alt = 1'b0;
    if (opcode == OpReg) begin
      alu_b   = rs2_val;
      alu_alt = funct7[5];
    end else if (opcode == OpStore) begin
      alu_b  = imm_s;
      alu_f3 = 3'b000;
    end else if (opcode == OpLoad) begin
      alu_f3 = 3'b000;
    end else if ((opcode == OpImm) && (funct3 == 3'b101)) begin
      alu_alt = funct7[5];
    end
  end

  always_comb begin
    unique case (alu_f3)
      3'b000:  alu_res = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001:  alu_res = rs1_val << alu_b[4:0];
      3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_res = {31'd0, rs1_val < alu_b};
      3'b100:  alu_res = rs1_val ^ alu_b;
      3'b101:  alu_res = alu_alt ? $unsigned($signed(rs1_val) >>> alu_b[4:0])
                                 : (rs1_val >> alu_b[4:0]);
      3'b110:  alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_cond = (rs1_val == rs2_val);
      3'b001:  br_cond = (rs1_val != rs2_val);
      3'b100:  br_cond = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_cond = (rs1_val < rs2_val);
      3'b111:  br_cond = (rs1_val >= rs2_val);
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    case (alu_res[1:0])
      2'b00:   ld_byte = dm_rdata[7:0];
      2'b01:   ld_byte = dm_rdata[15:8];
      2'b10:   ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half = alu_res[1] ? dm_rdata[31:16] : dm_rdata[15:0];
  end

  // Store lanes: data is replicated across the word and byte enables pick the lane.
  always_comb begin
    dm_be    = 4'b1111;
    dm_wdata = rs2_val;
    if (funct3[1:0] == 2'b00) begin
      dm_be    = 4'b0001 << alu_res[1:0];
      dm_wdata = {4{rs2_val[7:0]}};
    end else if (funct3[1:0] == 2'b01) begin
      dm_be    = alu_res[1] ? 4'b1100 : 4'b0011;
      dm_wdata = {2{rs2_val[15:0]}};
    end
  end

  always_comb begin
    pc_next  = pc_plus4;
    br_taken = 1'b0;
    jump     = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    dm_we    = 1'b0;
    case (opcode)
      OpLui: begin
        rf_we    = 1'b1;
        rf_wdata = imm_u;
      end
      OpAuipc: begin
        rf_we    = 1'b1;
        rf_wdata = pc_out + imm_u;
      end
      OpJal: begin
        jump     = 1'b1;
        rf_we    = 1'b1;
        rf_wdata = pc_plus4;
        pc_next  = pc_out + imm_j;
      end
      OpJalr: begin
        if (funct3 == 3'b000) begin
          jump     = 1'b1;
          rf_we    = 1'b1;
          rf_wdata = pc_plus4;
          pc_next  = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OpBranch: begin
        if (br_cond) begin
          br_taken = 1'b1;
          pc_next  = pc_out + imm_b;
        end
      end
      OpLoad: begin
        rf_we = 1'b1;
        case (funct3)
          3'b000:  rf_wdata = {{24{ld_byte[7]}}, ld_byte};
          3'b001:  rf_wdata = {{16{ld_half[15]}}, ld_half};
          3'b010:  rf_wdata = dm_rdata;
          3'b100:  rf_wdata = {24'd0, ld_byte};
          3'b101:  rf_wdata = {16'd0, ld_half};
          default: rf_we = 1'b0;
        endcase
      end
      OpStore: dm_we = (funct3 <= 3'b010);
      OpImm:   rf_we = 1'b1;
      OpReg: begin
        rf_we = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc_out <= RESET_PC;
    else     pc_out <= pc_next;
  end
endmodule

// File: tb/tb_single_cycle_processor.sv
// Directed plus random-program bench for single_cycle_processor, checked against an
// instruction-level reference model that executes the same program from its own memories.

module tb_single_cycle_processor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  single_cycle_processor dut (
    .clk (clk),
    .rst (rst)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] m_reg  [32];
  logic [31:0] m_imem [1024];
  logic [31:0] m_dmem [1024];
  logic [31:0] m_pc;
  logic        m_br, m_jmp, st_valid;
  int unsigned st_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm20, rd, op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] ins);
    m_imem[addr >> 2] = ins;
    dut.inst_mem_i.mem[addr >> 2] = ins;
  endtask

  function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    int unsigned sh = b % 32;
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return (alt && a[31]) ? ~((~a) >> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Executes one instruction on the model state and reports its branch/jump flags.
  task automatic iss_step();
    logic [31:0] ins, a, b, val, addr, w, mask, next;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    int unsigned sh, idx;
    bit wr = 0;
    ins   = m_imem[(m_pc >> 2) % 1024];
    op    = ins[6:0];
    rd    = ins[11:7];
    f3    = ins[14:12];
    f7    = ins[31:25];
    a     = m_reg[ins[19:15]];
    b     = m_reg[ins[24:20]];
    imm_i = $signed(ins[31:20]);
    imm_s = $signed({ins[31:25], ins[11:7]});
    imm_b = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
    imm_j = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
    imm_u = ins & 32'hffff_f000;
    next  = m_pc + 4;
    val   = 0;
    m_br  = 0;
    m_jmp = 0;
    st_valid = 0;
    case (op)
      7'h37: begin wr = 1; val = imm_u; end
      7'h17: begin wr = 1; val = m_pc + imm_u; end
      7'h6f: begin wr = 1; m_jmp = 1; val = m_pc + 4; next = m_pc + imm_j; end
      7'h67: if (f3 == 0) begin
        wr = 1; m_jmp = 1; val = m_pc + 4; next = (a + imm_i) & 32'hffff_fffe;
      end
      7'h63: begin
        case (f3)
          3'd0: m_br = (a == b);
          3'd1: m_br = (a != b);
          3'd4: m_br = ($signed(a) < $signed(b));
          3'd5: m_br = ($signed(a) >= $signed(b));
          3'd6: m_br = (a < b);
          3'd7: m_br = (a >= b);
          default: m_br = 0;
        endcase
        if (m_br) next = m_pc + imm_b;
      end
      7'h03: begin
        addr = a + imm_i;
        w = m_dmem[(addr >> 2) % 1024];
        wr = 1;
        case (f3)
          3'd0: begin val = (w >> (8 * addr[1:0])) & 32'hff; if (val >= 128) val = val - 256; end
          3'd1: begin
            val = (w >> (addr[1] ? 16 : 0)) & 32'hffff;
            if (val >= 32768) val = val - 65536;
          end
          3'd2: val = w;
          3'd4: val = (w >> (8 * addr[1:0])) & 32'hff;
          3'd5: val = (w >> (addr[1] ? 16 : 0)) & 32'hffff;
          default: wr = 0;
        endcase
      end
      7'h23: if (f3 <= 2) begin
        addr = a + imm_s;
        idx = (addr >> 2) % 1024;
        w = m_dmem[idx];
        if (f3 == 0) begin
          sh = 8 * addr[1:0]; mask = 32'hff << sh; w = (w & ~mask) | ((b & 32'hff) << sh);
        end else if (f3 == 1) begin
          sh = addr[1] ? 16 : 0; mask = 32'hffff << sh; w = (w & ~mask) | ((b & 32'hffff) << sh);
        end else begin
          w = b;
        end
        m_dmem[idx] = w;
        st_valid = 1;
        st_idx = idx;
      end
      7'h13: begin wr = 1; val = arith(f3, (f3 == 5) && ins[30], a, imm_i); end
      7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
        wr = 1; val = arith(f3, ins[30], a, b);
      end
      default: ;
    endcase
    if (wr && rd != 0) m_reg[rd] = val;
    m_pc = next;
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic run_step();
    check("pc", dut.pc_out, m_pc);
    iss_step();
    check("br_taken", {31'd0, dut.br_taken}, {31'd0, m_br});
    check("jump", {31'd0, dut.jump}, {31'd0, m_jmp});
    @(posedge clk);
    @(negedge clk);
    for (int i = 1; i < 32; i++)
      check($sformatf("x%0d", i), dut.reg_file_i.reg_mem[i], m_reg[i]);
    if (st_valid) check("dmem store", dut.data_mem_i.mem[st_idx], m_dmem[st_idx]);
  endtask

  function automatic logic [31:0] gen(input logic [31:0] pc);
    logic [31:0] rd, rs1, rs2, f3, imm;
    int lf[5] = '{0, 1, 2, 4, 5};
    int bf[6] = '{0, 1, 4, 5, 6, 7};
    rd  = $urandom_range(0, 31);
    rs1 = $urandom_range(0, 31);
    rs2 = $urandom_range(0, 31);
    f3  = $urandom_range(0, 7);
    case ($urandom_range(0, 7))
      0: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0,
                      rs2, rs1, f3, rd);
      1: begin
        if (f3 == 1) imm = $urandom_range(0, 31);
        else if (f3 == 5) imm = $urandom_range(0, 31) | ($urandom_range(0, 1) << 10);
        else imm = $urandom_range(0, 4095);
        return enc_i(imm, rs1, f3, rd, 'h13);
      end
      2: return enc_u($urandom, rd, $urandom_range(0, 1) == 1 ? 'h37 : 'h17);
      3: return enc_i($urandom_range(0, 255), 0, lf[$urandom_range(0, 4)], rd, 'h03);
      4: return enc_s($urandom_range(0, 255), rs2, 0, $urandom_range(0, 2));
      5: return enc_b(8, rs2, rs1, bf[$urandom_range(0, 5)]);
      6: return ($urandom_range(0, 1) == 1) ? enc_j(8, rd) : enc_i(pc + 9, 0, 0, rd, 'h67);
      default: return ($urandom_range(0, 1) == 1) ? 32'h0000_000f : 32'h0000_0073;
    endcase
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) begin
      m_imem[i] = 0;
      dut.inst_mem_i.mem[i] = 0;
      m_dmem[i] = $urandom;
      dut.data_mem_i.mem[i] = m_dmem[i];
    end
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = (i == 0) ? 32'd0 : $urandom;
      dut.reg_file_i.reg_mem[i] = m_reg[i];
    end
    dut.reg_file_i.reg_mem[0] = 32'hdead_beef;
    m_reg[1] = 5; dut.reg_file_i.reg_mem[1] = 5;
    m_reg[2] = 7; dut.reg_file_i.reg_mem[2] = 7;

    put(0,  32'h0020_81b3);
    put(4,  enc_s(0, 3, 0, 2));
    put(8,  enc_b(8, 1, 1, 0));
    put(12, enc_i(1, 0, 0, 6, 'h13));
    put(16, enc_b(8, 1, 1, 1));
    put(20, enc_j(12, 5));
    put(24, enc_i(0, 0, 2, 4, 'h03));
    put(28, enc_j(12, 0));
    put(32, enc_i(0, 5, 0, 0, 'h67));
    put(40, enc_i(5, 0, 0, 0, 'h13));
    put(44, enc_i(0, 0, 0, 15, 'h13));
    put(48, enc_i(-128, 0, 0, 7, 'h13));
    put(52, enc_s(4, 7, 0, 2));
    put(56, enc_i(4, 0, 0, 4, 'h03));
    put(60, enc_i(4, 0, 4, 4, 'h03));
    put(64, enc_i(1, 0, 0, 8, 'h13));
    put(68, enc_r(32, 8, 0, 0, 9));
    put(72, enc_u(32'h80000, 10, 'h37));
    put(76, enc_i(31, 0, 0, 11, 'h13));
    put(80, enc_r(32, 11, 10, 5, 12));
    put(84, enc_r(0, 9, 8, 3, 13));
    put(88, enc_j(168, 0));
    for (int k = 0; k < 200; k++) put(256 + 4 * k, gen(256 + 4 * k));

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset pc", dut.pc_out, 32'd0);
    check("x1 survives reset", dut.reg_file_i.reg_mem[1], 32'd5);
    rst = 1'b0;
    m_pc = 0;

    run_step();
    check("add x3", dut.reg_file_i.reg_mem[3], 32'd12);
    check("pc after add", dut.pc_out, 32'd4);
    run_step();
    check("sw word0", dut.data_mem_i.mem[0], 32'd12);
    check("beq taken", {31'd0, dut.br_taken}, 32'd1);
    run_step();
    check("beq target", dut.pc_out, 32'd16);
    check("bne not taken", {31'd0, dut.br_taken}, 32'd0);
    run_step();
    check("bne fallthrough", dut.pc_out, 32'd20);
    check("jal jump", {31'd0, dut.jump}, 32'd1);
    run_step();
    check("jal link x5", dut.reg_file_i.reg_mem[5], 32'd24);
    check("jal target", dut.pc_out, 32'd32);
    run_step();
    check("jalr target", dut.pc_out, 32'd24);
    run_step();
    check("lw x4", dut.reg_file_i.reg_mem[4], 32'd12);
    run_step();
    check("jal x0 target", dut.pc_out, 32'd40);
    run_step();
    run_step();
    check("x0 reads zero", dut.reg_file_i.reg_mem[15], 32'd0);
    run_step();
    run_step();
    run_step();
    check("lb sign", dut.reg_file_i.reg_mem[4], 32'hffff_ff80);
    run_step();
    check("lbu zero", dut.reg_file_i.reg_mem[4], 32'h0000_0080);
    run_step();
    run_step();
    check("sub 0-1", dut.reg_file_i.reg_mem[9], 32'hffff_ffff);
    run_step();
    run_step();
    run_step();
    check("sra by 31", dut.reg_file_i.reg_mem[12], 32'hffff_ffff);
    run_step();
    check("sltu 1,-1", dut.reg_file_i.reg_mem[13], 32'd1);
    run_step();
    check("jump to random code", dut.pc_out, 32'd256);

    n = 0;
    while (m_pc >= 256 && m_pc < 256 + 800 && n < 300) begin
      run_step();
      n++;
    end
    check("pc after random run", dut.pc_out, m_pc);

    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid-run reset pc", dut.pc_out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    for (int i = 1; i < 32; i++)
      check($sformatf("x%0d held in reset", i), dut.reg_file_i.reg_mem[i], m_reg[i]);
    for (int i = 0; i < 64; i++)
      check($sformatf("dmem%0d held in reset", i), dut.data_mem_i.mem[i], m_dmem[i]);
    rst = 1'b0;
    m_pc = 0;
    run_step();
    run_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
